// File: rtl/instruction_fetch.sv
// Fetch stage for the MIPS-subset CPU: owns the PC, issues one-word reads to
// instruction memory and holds each returned instruction until the decoder takes it.
module instruction_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  input  logic        dec_ready,
  input  logic        redirect,
  input  logic [1:0]  redirect_kind,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] fetch_count,
  output logic        fault
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALT} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [7:0]  wait_cnt;
  logic        consume;
  logic        rsp;
  logic        timeout;
  logic        jr_misaligned;
  logic [31:0] next_pc;

  function automatic logic [31:0] branch_target(input logic [31:0] base_plus4,
                                                input logic [15:0] imm);
    logic signed [31:0] ofs;
    ofs = {{14{imm[15]}}, imm, 2'b00};
    return base_plus4 + $unsigned(ofs);
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] base_plus4,
                                              input logic [25:0] index);
    return {base_plus4[31:28], index, 2'b00};
  endfunction

  always_comb begin
    consume       = (state == HOLD) && dec_ready;
    rsp           = (state == WAIT) && imem_rvalid;
    timeout       = (state == WAIT) && !imem_rvalid && (wait_cnt == WAIT_LAST);
    jr_misaligned = redirect && (redirect_kind == 2'b10) && (jr_target[1:0] != 2'b00);

    // Reserved kind 11 falls through to the sequential address.
    next_pc = pc_plus4;
    if (redirect) begin
      unique case (redirect_kind)
        2'b00:   next_pc = branch_target(pc_plus4, branch_imm);
        2'b01:   next_pc = jump_target(pc_plus4, jump_index);
        2'b10:   next_pc = jr_target;
        default: next_pc = pc_plus4;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: state_nxt = WAIT;
      WAIT: begin
        if (rsp)          state_nxt = HOLD;
        else if (timeout) state_nxt = HALT;
      end
      HOLD: begin
        if (consume) state_nxt = jr_misaligned ? HALT : FETCH;
      end
      HALT: state_nxt = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC_RESET;
      imem_req    <= 1'b0;
      imem_addr   <= 32'h0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      pc_plus4    <= 32'h0;
      instr_valid <= 1'b0;
      fetch_count <= 32'h0;
      fault       <= 1'b0;
      wait_cnt    <= 8'h0;
    end else begin
      // The strobe is registered, so it is seen during the first WAIT cycle.
      imem_req <= (state == FETCH);
      if (state == FETCH) begin
        imem_addr <= pc;
        wait_cnt  <= 8'h0;
      end
      if ((state == WAIT) && !imem_rvalid && !timeout)
        wait_cnt <= wait_cnt + 8'd1;
      if (rsp) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        pc_plus4    <= pc + 32'd4;
        instr_valid <= 1'b1;
      end
      if (timeout)
        fault <= 1'b1;
      // A misaligned JR is still counted as consumed; the PC stays frozen.
      if (consume) begin
        instr_valid <= 1'b0;
        fetch_count <= fetch_count + 32'd1;
        if (jr_misaligned) fault <= 1'b1;
        else               pc    <= next_pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: transaction-level reference model compared every
// cycle, directed redirect/fault/reset scenarios, then randomized traffic.
module tb_instruction_fetch;
  localparam int MAXW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        dec_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [1:0]  redirect_kind = 2'b00;
  logic [15:0] branch_imm = 16'h0;
  logic [25:0] jump_index = 26'h0;
  logic [31:0] jr_target = 32'h0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr, instr, instr_pc, pc_plus4, fetch_count;
  logic        instr_valid, fault;

  // Second instance checks the 32-bit PC wrap from the top of memory.
  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = 32'h1234_5678;
  logic        ready2 = 1'b1;
  logic        redir2 = 1'b0;
  logic [1:0]  kind2 = 2'b00;
  logic [15:0] imm2 = 16'h0;
  logic [25:0] idx2 = 26'h0;
  logic [31:0] jr2 = 32'h0;
  logic        req2, vld2, fault2;
  logic [31:0] addr2, instr2, ipc2, p4_2, cnt2;

  instruction_fetch #(.PC_RESET(32'h0000_0000), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .instr(instr),
    .instr_valid(instr_valid), .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .dec_ready(dec_ready), .redirect(redirect), .redirect_kind(redirect_kind),
    .branch_imm(branch_imm), .jump_index(jump_index), .jr_target(jr_target),
    .fetch_count(fetch_count), .fault(fault));

  instruction_fetch #(.PC_RESET(32'hFFFF_FFFC), .MAX_WAIT(MAXW)) dut2 (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_rdata(rdata2), .imem_rvalid(rvalid2), .instr(instr2),
    .instr_valid(vld2), .instr_pc(ipc2), .pc_plus4(p4_2),
    .dec_ready(ready2), .redirect(redir2), .redirect_kind(kind2),
    .branch_imm(imm2), .jump_index(idx2), .jr_target(jr2),
    .fetch_count(cnt2), .fault(fault2));

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Reference model: is an instruction held, is the unit halted, and how many
  // cycles have elapsed since the current fetch attempt began (0 = issue cycle).
  bit          m_halt, m_have, m_fault;
  int          m_age;
  logic [31:0] m_pc, m_count, m_instr, m_ipc, m_p4;

  // Stimulus knobs
  bit          k_reset, k_glitch;
  int          k_ready, k_mem, k_redir;
  logic        f_redirect;
  logic [1:0]  f_kind;
  logic [15:0] f_imm;
  logic [25:0] f_idx;
  logic [31:0] f_jr;

  bit          mem_pend;
  int          mem_delay;
  int          cyc;

  logic        obs_req, obs_valid, obs_fault;
  logic [31:0] obs_addr, obs_count, obs_instr, obs_ipc;
  int          obs_cyc;

  bit          mon2;
  int          p2;

  function automatic logic [31:0] model_next(input logic [31:0] ipc, input logic redir,
                                             input logic [1:0] kind, input logic [15:0] imm,
                                             input logic [25:0] idx, input logic [31:0] jr);
    int off;
    if (!redir || kind == 2'd3) return ipc + 32'd4;
    if (kind == 2'd0) begin
      off = int'($signed(imm)) * 4;
      return ipc + 32'd4 + 32'(off);
    end
    if (kind == 2'd1) return ((ipc + 32'd4) & 32'hF000_0000) + 32'(idx) * 32'd4;
    return jr;
  endfunction

  task automatic model_reset();
    m_halt = 0; m_have = 0; m_fault = 0; m_age = 0;
    m_pc = 32'h0; m_count = 32'h0; m_instr = 32'h0; m_ipc = 32'h0; m_p4 = 32'h0;
  endtask

  task automatic cycle();
    logic        rv;
    logic [31:0] rd;
    logic        exp_req;
    logic [31:0] np;
    @(negedge clk);
    obs_req = imem_req; obs_addr = imem_addr; obs_valid = instr_valid;
    obs_fault = fault; obs_count = fetch_count; obs_instr = instr; obs_ipc = instr_pc;
    obs_cyc = cyc;

    exp_req = !m_halt && !m_have && (m_age == 1);
    chkb("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chkb("instr_valid", instr_valid, m_have);
    if (m_have) begin
      chk("instr", instr, m_instr);
      chk("instr_pc", instr_pc, m_ipc);
      chk("pc_plus4", pc_plus4, m_p4);
    end
    chk("fetch_count", fetch_count, m_count);
    chkb("fault", fault, m_fault);

    if (mon2 && req2) begin
      if (p2 == 0) chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
      else         chk("wrap_next_addr", addr2, 32'h0000_0000);
      p2++;
      if (p2 == 2) mon2 = 0;
    end
    if (mon2 && vld2) begin
      chk("wrap_instr_pc", ipc2, 32'hFFFF_FFFC);
      chk("wrap_pc_plus4", p4_2, 32'h0000_0000);
    end
    rvalid2 = req2;

    reset = k_reset;
    case (k_ready)
      0:       dec_ready = 1'b1;
      1:       dec_ready = 1'($urandom_range(0, 1));
      default: dec_ready = 1'b0;
    endcase
    redirect_kind = 2'($urandom_range(0, 3));
    branch_imm    = 16'($urandom);
    jump_index    = 26'($urandom);
    jr_target     = ($urandom_range(0, 19) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
    redirect      = (k_redir == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (k_redir == 2) begin
      redirect = f_redirect; redirect_kind = f_kind; branch_imm = f_imm;
      jump_index = f_idx; jr_target = f_jr;
    end

    rv = 1'b0;
    rd = $urandom;
    if (imem_req) begin
      mem_pend = 1;
      case (k_mem)
        0:       mem_delay = 0;
        1:       mem_delay = $urandom_range(0, 3);
        default: mem_delay = 1000000;
      endcase
    end
    if (mem_pend) begin
      if (mem_delay == 0) begin rv = 1'b1; mem_pend = 0; end
      else mem_delay--;
    end
    if (k_mem == 1 && !mem_pend && $urandom_range(0, 9) == 0) rv = 1'b1;
    if (k_reset) begin mem_pend = 0; rv = 1'b0; end
    if (k_glitch) rv = 1'b1;
    imem_rvalid = rv;
    imem_rdata  = rd;

    if (reset) model_reset();
    else if (m_halt) begin
    end else if (m_have) begin
      if (dec_ready) begin
        m_count = m_count + 32'd1;
        m_have = 0;
        m_age = 0;
        np = model_next(m_ipc, redirect, redirect_kind, branch_imm, jump_index, jr_target);
        if (redirect && redirect_kind == 2'd2 && (jr_target % 4) != 0) begin
          m_fault = 1; m_halt = 1;
        end else m_pc = np;
      end
    end else if (m_age == 0) m_age = 1;
    else if (rv) begin
      m_have = 1; m_instr = rd; m_ipc = m_pc; m_p4 = m_pc + 32'd4;
    end else if (m_age == MAXW) begin
      m_fault = 1; m_halt = 1;
    end else m_age++;

    cyc = reset ? 0 : cyc + 1;
  endtask

  task automatic wait_valid(input string what);
    int n;
    n = 0;
    do begin cycle(); n++; end while (!obs_valid && n < 60);
    chkb({what, "_valid_seen"}, obs_valid, 1'b1);
  endtask

  task automatic redirect_to(input string what, input logic r, input logic [1:0] kind,
                             input logic [15:0] imm, input logic [25:0] idx,
                             input logic [31:0] jr, output logic [31:0] addr);
    int n;
    k_ready = 2; k_redir = 0;
    wait_valid(what);
    f_redirect = r; f_kind = kind; f_imm = imm; f_idx = idx; f_jr = jr;
    k_redir = 2; k_ready = 0;
    cycle();
    k_redir = 0; k_ready = 2;
    n = 0;
    do begin cycle(); n++; end while (!obs_req && n < 20);
    chkb({what, "_req_seen"}, obs_req, 1'b1);
    addr = obs_addr;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] addrs[8];
    int          pcyc[8];
    int          np;
    int          n;
    int          fcyc;
    logic [31:0] cnt0;
    bit          saw_req;

    k_reset = 1; k_glitch = 0; k_ready = 0; k_mem = 0; k_redir = 0;
    f_redirect = 0; f_kind = 0; f_imm = 0; f_idx = 0; f_jr = 0;
    mem_pend = 0; mem_delay = 0; cyc = 0; mon2 = 0; p2 = 0;
    model_reset();
    repeat (3) cycle();

    // Reset values and sequential fetch with a one-cycle memory
    k_reset = 0; mon2 = 1;
    cycle();
    chkb("rst_instr_valid", obs_valid, 1'b0);
    chkb("rst_imem_req", obs_req, 1'b0);
    chk("rst_count", obs_count, 32'h0);
    chkb("rst_fault", obs_fault, 1'b0);
    chk("rst_instr", obs_instr, 32'h0);
    chk("rst_instr_pc", obs_ipc, 32'h0);
    np = 0;
    repeat (13) begin
      cycle();
      if (obs_req && np < 8) begin addrs[np] = obs_addr; pcyc[np] = obs_cyc; np++; end
    end
    chk("seq_count_after_12", obs_count, 32'd4);
    chk("seq_pulses", 32'(np), 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", addrs[i], 32'(i * 4));
      chk("seq_pulse_cycle", 32'(pcyc[i]), 32'(1 + 3 * i));
    end
    chk("wrap_pulses", 32'(p2), 32'd2);

    // Decoder stall
    k_ready = 2;
    wait_valid("stall");
    cnt0 = m_count;
    saw_req = 0;
    repeat (5) begin
      cycle();
      saw_req |= obs_req;
      chkb("stall_valid", obs_valid, 1'b1);
    end
    chk("stall_count", obs_count, cnt0);
    chkb("stall_no_req", saw_req, 1'b0);

    // Branch, jump and JR redirects
    redirect_to("jr_100", 1, 2'd2, 16'h0, 26'h0, 32'h0000_0100, a);
    chk("jr_to_100", a, 32'h0000_0100);
    redirect_to("br_m1", 1, 2'd0, 16'hFFFF, 26'h0, 32'h0, a);
    chk("branch_m1", a, 32'h0000_0100);
    redirect_to("br_p3", 1, 2'd0, 16'h0003, 26'h0, 32'h0, a);
    chk("branch_p3", a, 32'h0000_0110);
    redirect_to("jr_hi", 1, 2'd2, 16'h0, 26'h0, 32'h8000_0010, a);
    chk("jr_to_80000010", a, 32'h8000_0010);
    redirect_to("jump", 1, 2'd1, 16'h0, 26'h0000040, 32'h0, a);
    chk("jump_index_40", a, 32'h8000_0100);
    redirect_to("jr_2000", 1, 2'd2, 16'h0, 26'h0, 32'h0000_2000, a);
    chk("jr_to_2000", a, 32'h0000_2000);
    redirect_to("kind11", 1, 2'd3, 16'h8000, 26'h3FFFFFF, 32'h0000_0001, a);
    chk("reserved_kind_seq", a, 32'h0000_2004);
    redirect_to("noredir", 0, 2'd2, 16'h8000, 26'h3FFFFFF, 32'h0000_0003, a);
    chk("no_redirect_seq", a, 32'h0000_2008);

    // Misaligned JR
    k_ready = 2;
    wait_valid("jr_bad");
    cnt0 = m_count;
    f_redirect = 1; f_kind = 2'd2; f_jr = 32'h0000_2002; k_redir = 2; k_ready = 0;
    cycle();
    k_redir = 0; k_ready = 0;
    saw_req = 0;
    repeat (10) begin cycle(); saw_req |= obs_req; end
    chkb("jr_misaligned_fault", obs_fault, 1'b1);
    chkb("jr_misaligned_no_req", saw_req, 1'b0);
    chk("jr_misaligned_count", obs_count, cnt0 + 32'd1);

    // Memory timeout
    k_reset = 1; cycle();
    k_reset = 0; k_mem = 2;
    n = 0; fcyc = -1;
    do begin cycle(); n++; end while (!obs_fault && n < 60);
    if (obs_fault) fcyc = obs_cyc;
    chkb("timeout_fault", obs_fault, 1'b1);
    chk("timeout_cycle", 32'(fcyc), 32'd17);

    // Reset during WAIT with a late response
    k_mem = 0; k_ready = 0;
    k_reset = 1; cycle();
    k_reset = 0;
    repeat (8) cycle();
    k_mem = 2;
    n = 0;
    do begin cycle(); n++; end while (!obs_req && n < 20);
    chkb("rstw_in_wait", obs_req, 1'b1);
    k_reset = 1; cycle();
    k_reset = 0; k_glitch = 1; cycle();
    chkb("rstw_valid", obs_valid, 1'b0);
    chk("rstw_count", obs_count, 32'h0);
    chkb("rstw_req", obs_req, 1'b0);
    k_glitch = 0; k_mem = 0;
    cycle();
    chkb("rstw_refetch_req", obs_req, 1'b1);
    chk("rstw_refetch_addr", obs_addr, 32'h0);
    chkb("rstw_late_ignored", obs_valid, 1'b0);

    // Randomized traffic
    k_ready = 1; k_mem = 1; k_redir = 1;
    k_reset = 1; cycle();
    for (int i = 0; i < 4000; i++) begin
      k_reset = ($urandom_range(0, 299) == 0);
      cycle();
    end
    k_reset = 0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of the instruction decoder in the MIPS-subset CPU (LW, SW, J, JR, JAL, BNE, BEQ, XORI, ADDI, ADD, SUB, SLT). Owns the PC and issues word reads to instruction memory. Holds each returned instruction stable for the decoder until it is consumed. Computes the next PC from sequential, branch, jump or JR redirects supplied at consume time.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset.
MAX_WAIT, 16, imem cycles tolerated in WAIT before timeout fault (1..255).

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  one-cycle read strobe
imem_addr  out  32  word address of read; equals pc while imem_req=1
imem_rdata  in  32  read data, sampled only when imem_rvalid=1 in WAIT
imem_rvalid  in  1  read data valid
instr  out  32  instruction to decoder; opcode is instr[31:26]
instr_valid  out  1  instr/instr_pc/pc_plus4 are valid
instr_pc  out  32  address of instr
pc_plus4  out  32  instr_pc+4 (JAL link value)
dec_ready  in  1  decoder consumes instr when instr_valid & dec_ready
redirect  in  1  take non-sequential next PC; sampled only on consume
redirect_kind  in  2  00 branch, 01 jump (J/JAL), 10 JR, 11 reserved (treated as sequential)
branch_imm  in  16  branch offset (instr[15:0])
jump_index  in  26  jump index (instr[25:0])
jr_target  in  32  register value for JR
fetch_count  out  32  number of consumed instructions
fault  out  1  sticky fault: misaligned JR target or memory timeout

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- States: FETCH, WAIT, HOLD, HALT.
- Reset values: state=FETCH, pc=PC_RESET, instr=0, instr_pc=0, pc_plus4=0, instr_valid=0, imem_req=0, fetch_count=0, fault=0, wait counter=0.
- imem_req and imem_addr are registered outputs.
- FETCH: imem_req=1, imem_addr=pc for exactly one cycle; next state WAIT. Any imem_rvalid seen during FETCH is ignored (memory latency is at least 1 cycle).
- WAIT:
  - When imem_rvalid=1: latch instr=imem_rdata, instr_pc=pc, pc_plus4=pc+4; next state HOLD.
  - Wait counter increments each WAIT cycle without imem_rvalid. On reaching MAX_WAIT: fault=1, next state HALT.
- HOLD: instr_valid=1; instr, instr_pc and pc_plus4 stay stable until consume.
- Consume (HOLD & dec_ready): instr_valid drops next cycle, fetch_count+1 (wraps 0xFFFFFFFF→0), next state FETCH with pc=next_pc.
- Minimum cycle per instruction: FETCH→WAIT→HOLD = 3 cycles with 1-cycle memory and dec_ready tied high.
- next_pc when redirect=0 or kind=11: instr_pc+4.
- next_pc for kind=00: instr_pc + 4 + (sign_extend(branch_imm) << 2), modulo 2^32.
- next_pc for kind=01: {pc_plus4[31:28], jump_index, 2'b00}.
- next_pc for kind=10: jr_target.
  - If jr_target[1:0]≠0: fault=1, next state HALT. Count still increments, since the JR was consumed.
- All PC arithmetic is 32-bit modulo. 0xFFFFFFFC+4 → 0x00000000.
- HALT: imem_req=0, instr_valid=0. State, pc and fault frozen until reset.
- redirect and its fields are don't-care outside consume cycles.
- Reset mid-operation (any state) returns all registers to reset values next cycle. Any outstanding read is abandoned. Instruction memory shares reset and flushes its response.
- reset and dec_ready asserted in the same cycle: reset wins, and fetch_count is not incremented.

Test Plan:
- Sequential fetch: PC_RESET=0, 1-cycle memory returning addr-based words, dec_ready=1 → imem_addr 0,4,8,C on every third cycle; instr_pc matches; fetch_count=4 after 12 cycles.
- Decoder stall: hold dec_ready=0 for 5 cycles in HOLD → instr/instr_pc stable and instr_valid=1 throughout; no imem_req; count unchanged.
- Branches: instr_pc=0x100, kind=00, imm=0xFFFF → next imem_addr 0x100. With imm=0x0003 → 0x110.
- Jump and JR: instr_pc=0x8000_0010, kind=01, index=0x0000040 → next imem_addr 0x8000_0100. kind=10, jr_target=0x0000_2000 → next imem_addr 0x2000.
- Faults: kind=10 with jr_target=0x0000_2002 → fault=1 and no further imem_req. Fresh run with rvalid withheld for MAX_WAIT=16 cycles → fault=1.
- Wrap and reset: PC_RESET=0xFFFF_FFFC, sequential consume → next imem_addr 0x0. Reset asserted during WAIT → next cycle state FETCH, count=0, instr_valid=0, and the late rvalid is ignored.
